// File: rtl/isi_channel.sv
// ---------------------------------------------------------------------------
// isi_channel
//
// Behavioural model of a band-limited serial channel. Each accepted symbol
// is passed through with unity main-cursor gain. Up to three post-cursor
// echoes of earlier symbols, each scaled by a signed Q0.7 coefficient, are
// added to it. The result is saturated to the sample width and registered,
// so the block has one clock of latency.
//
// Parameters
//   SIGNAL_RESOLUTION      sample width in bits, signed two's complement
//   PULSE_RESPONSE_LENGTH  number of cursors (main + post-cursors), 1..4
//   H1, H2, H3             post-cursor coefficients, signed Q0.7 (32 = 0.25)
//
// Ports
//   clk               in   1     rising-edge clock
//   rstn              in   1     asynchronous active-low reset
//   signal_in         in   SR    transmitted level, signed
//   signal_in_valid   in   1     signal_in carries a new symbol this cycle
//   signal_out        out  SR    received sample including ISI, signed
//   signal_out_valid  out  1     signal_out was updated this cycle
// ---------------------------------------------------------------------------
module isi_channel #(
  parameter int SIGNAL_RESOLUTION     = 8,
  parameter int PULSE_RESPONSE_LENGTH = 2,
  parameter int H1                    = 32,
  parameter int H2                    = 0,
  parameter int H3                    = 0
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [SIGNAL_RESOLUTION-1:0] signal_in,
  input  logic                         signal_in_valid,
  output logic [SIGNAL_RESOLUTION-1:0] signal_out,
  output logic                         signal_out_valid
);

  localparam int W  = SIGNAL_RESOLUTION;
  localparam int PW = 2 * W;
  localparam int SW = W + 3;

  // An out-of-range cursor count is clamped, so the block still elaborates.
  localparam int L = (PULSE_RESPONSE_LENGTH < 1) ? 1 :
                     (PULSE_RESPONSE_LENGTH > 4) ? 4 : PULSE_RESPONSE_LENGTH;

  // Post-cursors beyond the configured response length contribute nothing.
  localparam logic signed [PW-1:0] COEF1 = (L > 1) ? PW'(H1) : '0;
  localparam logic signed [PW-1:0] COEF2 = (L > 2) ? PW'(H2) : '0;
  localparam logic signed [PW-1:0] COEF3 = (L > 3) ? PW'(H3) : '0;

  // Saturation bounds expressed at the accumulator width.
  localparam logic signed [SW-1:0] SUM_MAX = {4'b0000, {(W-1){1'b1}}};
  localparam logic signed [SW-1:0] SUM_MIN = {4'b1111, {(W-1){1'b0}}};

  localparam logic [W-1:0] OUT_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] OUT_MIN = {1'b1, {(W-1){1'b0}}};

  logic signed [W-1:0]  hist1;
  logic signed [W-1:0]  hist2;
  logic signed [W-1:0]  hist3;

  logic signed [SW-1:0] tap1;
  logic signed [SW-1:0] tap2;
  logic signed [SW-1:0] tap3;
  logic signed [SW-1:0] main_ext;
  logic signed [SW-1:0] sum;
  logic [W-1:0]         sat_sample;

  // One echo term: a full-width signed product, then an arithmetic shift by
  // 7 to drop the Q0.7 fraction. The shift floors toward negative infinity.
  // The shifted value never exceeds 2^(W-1) in magnitude, so it fits the
  // accumulator width without loss.
  function automatic logic signed [SW-1:0] echo_term(
    input logic signed [W-1:0]  x,
    input logic signed [PW-1:0] coef
  );
    logic signed [PW-1:0] x_ext;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] shifted;
    x_ext   = {{W{x[W-1]}}, x};
    prod    = x_ext * coef;
    shifted = prod >>> 7;
    return shifted[SW-1:0];
  endfunction

  // Combinational datapath. The main cursor is added with unity gain. Three
  // spare bits of headroom hold the worst case of four full-scale terms.
  always_comb begin
    tap1       = echo_term(hist1, COEF1);
    tap2       = echo_term(hist2, COEF2);
    tap3       = echo_term(hist3, COEF3);
    main_ext   = {{3{signal_in[W-1]}}, signal_in};
    sum        = main_ext + tap1 + tap2 + tap3;
    sat_sample = sum[W-1:0];
    if (sum > SUM_MAX) begin
      sat_sample = OUT_MAX;
    end else if (sum < SUM_MIN) begin
      sat_sample = OUT_MIN;
    end
  end

  // Symbol history and output register. History and output advance only on
  // accepted symbols, so idle cycles leave the channel state and the last
  // output untouched.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hist1            <= '0;
      hist2            <= '0;
      hist3            <= '0;
      signal_out       <= '0;
      signal_out_valid <= 1'b0;
    end else begin
      signal_out_valid <= signal_in_valid;
      if (signal_in_valid) begin
        signal_out <= sat_sample;
        hist1      <= signal_in;
        hist2      <= hist1;
        hist3      <= hist2;
      end
    end
  end

endmodule

// File: tb/tb_isi_channel.sv
// ---------------------------------------------------------------------------
// tb_isi_channel
//
// Self-checking bench for isi_channel. It drives three instances from the
// same stimulus:
//   dut      default settings (L=2, H1=0.25)
//   dut_sat  H1=127, which exercises saturation
//   dut_l4   four cursors with a negative post-cursor
// A reference model computes each output from the convolution formula with
// integer arithmetic. A negedge process compares every instance against the
// model on every cycle. Directed sequences add literal expectations that pin
// the model.
// ---------------------------------------------------------------------------
module tb_isi_channel;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] signal_in;
  logic       signal_in_valid;

  logic [7:0] def_out;
  logic       def_valid;
  logic [7:0] sat_out;
  logic       sat_valid;
  logic [7:0] l4_out;
  logic       l4_valid;

  int checks = 0;
  int passes = 0;
  bit running = 1'b0;

  int hist [1:3] = '{0, 0, 0};
  int exp_def = 0;
  int exp_sat = 0;
  int exp_l4 = 0;
  bit exp_valid = 1'b0;

  always #5 clk = ~clk;

  isi_channel dut (
    .clk(clk), .rstn(rstn), .signal_in(signal_in), .signal_in_valid(signal_in_valid),
    .signal_out(def_out), .signal_out_valid(def_valid)
  );

  isi_channel #(.SIGNAL_RESOLUTION(8), .PULSE_RESPONSE_LENGTH(2), .H1(127)) dut_sat (
    .clk(clk), .rstn(rstn), .signal_in(signal_in), .signal_in_valid(signal_in_valid),
    .signal_out(sat_out), .signal_out_valid(sat_valid)
  );

  isi_channel #(.SIGNAL_RESOLUTION(8), .PULSE_RESPONSE_LENGTH(4),
                .H1(40), .H2(-20), .H3(10)) dut_l4 (
    .clk(clk), .rstn(rstn), .signal_in(signal_in), .signal_in_valid(signal_in_valid),
    .signal_out(l4_out), .signal_out_valid(l4_valid)
  );

  // floor(p / 128) for any sign of p
  function automatic int floor128(input int p);
    if (p >= 0) return p / 128;
    return -((-p + 127) / 128);
  endfunction

  // y = x + sum floor(x[n-k]*Hk/128), clamped to the 8-bit signed range
  function automatic int isi(input int x, input int h1, input int h2, input int h3, input int len);
    int y;
    y = x;
    if (len > 1) y += floor128(hist[1] * h1);
    if (len > 2) y += floor128(hist[2] * h2);
    if (len > 3) y += floor128(hist[3] * h3);
    if (y > 127) y = 127;
    if (y < -128) y = -128;
    return y;
  endfunction

  // Reference model: advances on accepted symbols and clears on reset.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hist = '{0, 0, 0};
      exp_def = 0;
      exp_sat = 0;
      exp_l4 = 0;
      exp_valid = 1'b0;
    end else begin
      exp_valid = signal_in_valid;
      if (signal_in_valid) begin
        exp_def = isi(int'($signed(signal_in)), 32, 0, 0, 2);
        exp_sat = isi(int'($signed(signal_in)), 127, 0, 0, 2);
        exp_l4  = isi(int'($signed(signal_in)), 40, -20, 10, 4);
        hist[3] = hist[2];
        hist[2] = hist[1];
        hist[1] = int'($signed(signal_in));
      end
    end
  end

  task automatic checkOutput(input string name, input int act_out, input bit act_valid,
                             input int exp_out, input bit exp_v);
    checks++;
    if (act_out == exp_out && act_valid == exp_v) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got out=%0d valid=%0b, expected out=%0d valid=%0b",
               name, act_out, act_valid, exp_out, exp_v);
    end
  endtask

  // Compare every instance against the model on every cycle.
  always @(negedge clk) begin
    if (running) begin
      checkOutput("model_def", int'($signed(def_out)), def_valid, exp_def, exp_valid);
      checkOutput("model_sat", int'($signed(sat_out)), sat_valid, exp_sat, exp_valid);
      checkOutput("model_l4",  int'($signed(l4_out)),  l4_valid,  exp_l4,  exp_valid);
    end
  end

  task automatic applyStimulus(input bit v, input int x);
    @(negedge clk);
    #1;
    signal_in = 8'(x);
    signal_in_valid = v;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset(input int cycles);
    @(negedge clk);
    #1;
    rstn = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      stepCycle();
      checkOutput("reset_hold", int'($signed(def_out)), def_valid, 0, 1'b0);
    end
    @(negedge clk);
    #1;
    signal_in_valid = 1'b0;
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0;
    signal_in = 8'd84;
    signal_in_valid = 1'b1;
    running = 1'b1;

    // Reset held with a valid input present
    doReset(3);

    // 84 then 0
    applyStimulus(1'b1, 84);
    stepCycle();
    checkOutput("first_after_reset", int'($signed(def_out)), def_valid, 84, 1'b1);
    applyStimulus(1'b1, 0);
    stepCycle();
    checkOutput("echo_only", int'($signed(def_out)), def_valid, 21, 1'b1);

    // 84, 84, -84, -28
    doReset(1);
    applyStimulus(1'b1, 84);   stepCycle();
    checkOutput("seq_0", int'($signed(def_out)), def_valid, 84, 1'b1);
    applyStimulus(1'b1, 84);   stepCycle();
    checkOutput("seq_1", int'($signed(def_out)), def_valid, 105, 1'b1);
    applyStimulus(1'b1, -84);  stepCycle();
    checkOutput("seq_2", int'($signed(def_out)), def_valid, -63, 1'b1);
    applyStimulus(1'b1, -28);  stepCycle();
    checkOutput("seq_3", int'($signed(def_out)), def_valid, -49, 1'b1);

    // Gap of invalid cycles with a distracting value on the input
    doReset(1);
    applyStimulus(1'b1, 84);   stepCycle();
    checkOutput("gap_first", int'($signed(def_out)), def_valid, 84, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, -128); stepCycle();
      checkOutput("gap_hold", int'($signed(def_out)), def_valid, 84, 1'b0);
    end
    applyStimulus(1'b1, 28);   stepCycle();
    checkOutput("gap_after", int'($signed(def_out)), def_valid, 49, 1'b1);

    // Saturation with H1=127
    doReset(1);
    applyStimulus(1'b1, 127);  stepCycle();
    checkOutput("sat_pos_0", int'($signed(sat_out)), sat_valid, 127, 1'b1);
    applyStimulus(1'b1, 127);  stepCycle();
    checkOutput("sat_pos_1", int'($signed(sat_out)), sat_valid, 127, 1'b1);
    doReset(1);
    applyStimulus(1'b1, -128); stepCycle();
    checkOutput("sat_neg_0", int'($signed(sat_out)), sat_valid, -128, 1'b1);
    applyStimulus(1'b1, -128); stepCycle();
    checkOutput("sat_neg_1", int'($signed(sat_out)), sat_valid, -128, 1'b1);

    // Four-cursor impulse response: 100, 31, floor(-15.625) = -16, 7
    doReset(1);
    applyStimulus(1'b1, 100);  stepCycle();
    checkOutput("l4_main", int'($signed(l4_out)), l4_valid, 100, 1'b1);
    applyStimulus(1'b1, 0);    stepCycle();
    checkOutput("l4_h1", int'($signed(l4_out)), l4_valid, 31, 1'b1);
    applyStimulus(1'b1, 0);    stepCycle();
    checkOutput("l4_h2", int'($signed(l4_out)), l4_valid, -16, 1'b1);
    applyStimulus(1'b1, 0);    stepCycle();
    checkOutput("l4_h3", int'($signed(l4_out)), l4_valid, 7, 1'b1);

    // Reset mid-stream discards history
    doReset(1);
    applyStimulus(1'b1, 84);   stepCycle();
    checkOutput("mid_pre", int'($signed(def_out)), def_valid, 84, 1'b1);
    @(negedge clk);
    #1;
    signal_in_valid = 1'b0;
    rstn = 1'b0;
    stepCycle();
    checkOutput("mid_reset", int'($signed(def_out)), def_valid, 0, 1'b0);
    @(negedge clk);
    #1;
    rstn = 1'b1;
    applyStimulus(1'b1, 28);   stepCycle();
    checkOutput("mid_post", int'($signed(def_out)), def_valid, 28, 1'b1);

    // Randomized traffic with PAM-4 and full-range values plus sporadic
    // asynchronous resets
    for (int i = 0; i < 600; i++) begin
      int lvl;
      bit v;
      v = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 1) == 1) begin
        case ($urandom_range(0, 3))
          0: lvl = -84;
          1: lvl = -28;
          2: lvl = 28;
          default: lvl = 84;
        endcase
      end else begin
        lvl = int'($urandom_range(0, 255)) - 128;
      end
      applyStimulus(v, lvl);
      if ($urandom_range(0, 59) == 0) begin
        #1;
        rstn = 1'b0;
        #4;
        rstn = 1'b1;
      end
    end

    @(negedge clk);
    @(negedge clk);
    running = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
